// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//
// Memory stage of the pipeline. Takes the execute-stage result, performs the
// data-memory access over a req/ack bus when the instruction is a load or
// store, and presents the write-back payload to WB.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   ex_*                     EX payload in (valid/ready handshake)
//   dmem_*                   data-memory bus (req held until ack)
//   mem_*                    WB payload out (valid/ready handshake)
//   mem_excp_ale             address-misaligned flag, qualified by mem_valid
//
// Non-memory ops and misaligned accesses complete in one cycle without
// touching the bus; aligned loads/stores go IDLE -> BUS -> HOLD -> IDLE.
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LSU_OP_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [DATA_WIDTH-1:0]     ex_pc,
  input  logic [DATA_WIDTH-1:0]     ex_inst,
  input  logic [DATA_WIDTH-1:0]     ex_result,
  input  logic [LSU_OP_WIDTH-1:0]   ex_lsu_op,
  input  logic [DATA_WIDTH-1:0]     ex_lsu_data,
  input  logic                      ex_rw_en,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rw_addr,

  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [DATA_WIDTH-1:0]     dmem_addr,
  output logic [3:0]                dmem_wstrb,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic                      dmem_ack,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,

  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [DATA_WIDTH-1:0]     mem_pc,
  output logic [DATA_WIDTH-1:0]     mem_inst,
  output logic                      mem_rw_en,
  output logic [REG_ADDR_WIDTH-1:0] mem_rw_addr,
  output logic [DATA_WIDTH-1:0]     mem_rw_data,
  output logic                      mem_excp_ale
);

  localparam logic [LSU_OP_WIDTH-1:0] OP_LB  = LSU_OP_WIDTH'(1);
  localparam logic [LSU_OP_WIDTH-1:0] OP_LH  = LSU_OP_WIDTH'(2);
  localparam logic [LSU_OP_WIDTH-1:0] OP_LW  = LSU_OP_WIDTH'(3);
  localparam logic [LSU_OP_WIDTH-1:0] OP_LBU = LSU_OP_WIDTH'(4);
  localparam logic [LSU_OP_WIDTH-1:0] OP_LHU = LSU_OP_WIDTH'(5);
  localparam logic [LSU_OP_WIDTH-1:0] OP_SB  = LSU_OP_WIDTH'(6);
  localparam logic [LSU_OP_WIDTH-1:0] OP_SH  = LSU_OP_WIDTH'(7);
  localparam logic [LSU_OP_WIDTH-1:0] OP_SW  = LSU_OP_WIDTH'(8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic                        dmem_req_q, dmem_req_d;
  logic                        dmem_we_q, dmem_we_d;
  logic [DATA_WIDTH-1:0]       dmem_addr_q, dmem_addr_d;
  logic [3:0]                  dmem_wstrb_q, dmem_wstrb_d;
  logic [DATA_WIDTH-1:0]       dmem_wdata_q, dmem_wdata_d;
  logic                        mem_valid_q, mem_valid_d;
  logic [DATA_WIDTH-1:0]       mem_pc_q, mem_pc_d;
  logic [DATA_WIDTH-1:0]       mem_inst_q, mem_inst_d;
  logic                        mem_rw_en_q, mem_rw_en_d;
  logic [REG_ADDR_WIDTH-1:0]   mem_rw_addr_q, mem_rw_addr_d;
  logic [DATA_WIDTH-1:0]       mem_rw_data_q, mem_rw_data_d;
  logic                        mem_ale_q, mem_ale_d;
  logic [LSU_OP_WIDTH-1:0]     op_q, op_d;
  logic [1:0]                  addr_lo_q, addr_lo_d;

  logic                        ex_accept;
  logic                        ex_is_load, ex_is_store, ex_misalign;
  logic [7:0]                  load_byte;
  logic [15:0]                 load_half;
  logic [DATA_WIDTH-1:0]       load_data;

  assign ex_ready  = (state_q == S_IDLE) && (!mem_valid_q || mem_ready);
  assign ex_accept = ex_valid && ex_ready;

  // Decode the incoming op; opcodes outside 1..8 behave as NONE.
  always_comb begin
    ex_is_load  = 1'b0;
    ex_is_store = 1'b0;
    ex_misalign = 1'b0;
    case (ex_lsu_op)
      OP_LB, OP_LBU: ex_is_load = 1'b1;
      OP_LH, OP_LHU: begin
        ex_is_load  = 1'b1;
        ex_misalign = ex_result[0];
      end
      OP_LW: begin
        ex_is_load  = 1'b1;
        ex_misalign = |ex_result[1:0];
      end
      OP_SB: ex_is_store = 1'b1;
      OP_SH: begin
        ex_is_store = 1'b1;
        ex_misalign = ex_result[0];
      end
      OP_SW: begin
        ex_is_store = 1'b1;
        ex_misalign = |ex_result[1:0];
      end
      default: ;
    endcase
  end

  // Pick the addressed lane out of the returned word and extend it according
  // to the op latched at accept time.
  always_comb begin
    case (addr_lo_q)
      2'd0:    load_byte = dmem_rdata[7:0];
      2'd1:    load_byte = dmem_rdata[15:8];
      2'd2:    load_byte = dmem_rdata[23:16];
      default: load_byte = dmem_rdata[31:24];
    endcase
    load_half = addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op_q)
      OP_LB:   load_data = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
      OP_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, load_byte};
      OP_LH:   load_data = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
      OP_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, load_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // Next-state and next-output logic for the IDLE/BUS/HOLD sequencer.
  always_comb begin
    state_d       = state_q;
    dmem_req_d    = dmem_req_q;
    dmem_we_d     = dmem_we_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_wstrb_d  = dmem_wstrb_q;
    dmem_wdata_d  = dmem_wdata_q;
    mem_valid_d   = mem_valid_q;
    mem_pc_d      = mem_pc_q;
    mem_inst_d    = mem_inst_q;
    mem_rw_en_d   = mem_rw_en_q;
    mem_rw_addr_d = mem_rw_addr_q;
    mem_rw_data_d = mem_rw_data_q;
    mem_ale_d     = mem_ale_q;
    op_d          = op_q;
    addr_lo_d     = addr_lo_q;

    case (state_q)
      S_IDLE: begin
        if (mem_valid_q && mem_ready) begin
          mem_valid_d = 1'b0;
        end
        if (ex_accept) begin
          mem_pc_d      = ex_pc;
          mem_inst_d    = ex_inst;
          mem_rw_addr_d = ex_rw_addr;
          mem_rw_data_d = ex_result;
          op_d          = ex_lsu_op;
          addr_lo_d     = ex_result[1:0];
          mem_ale_d     = 1'b0;
          if (!(ex_is_load || ex_is_store)) begin
            mem_valid_d = 1'b1;
            mem_rw_en_d = ex_rw_en;
          end else if (ex_misalign) begin
            // Fault without going to the bus; WB sees the flag and no write.
            mem_valid_d = 1'b1;
            mem_rw_en_d = 1'b0;
            mem_ale_d   = 1'b1;
          end else begin
            state_d      = S_BUS;
            mem_valid_d  = 1'b0;
            mem_rw_en_d  = ex_rw_en;
            dmem_req_d   = 1'b1;
            dmem_we_d    = ex_is_store;
            dmem_addr_d  = {ex_result[DATA_WIDTH-1:2], 2'b00};
            dmem_wstrb_d = 4'b0000;
            dmem_wdata_d = '0;
            if (ex_lsu_op == OP_SB) begin
              dmem_wstrb_d = 4'b0001 << ex_result[1:0];
              dmem_wdata_d = {4{ex_lsu_data[7:0]}};
            end else if (ex_lsu_op == OP_SH) begin
              dmem_wstrb_d = ex_result[1] ? 4'b1100 : 4'b0011;
              dmem_wdata_d = {2{ex_lsu_data[15:0]}};
            end else if (ex_lsu_op == OP_SW) begin
              dmem_wstrb_d = 4'b1111;
              dmem_wdata_d = ex_lsu_data;
            end
          end
        end
      end
      S_BUS: begin
        if (dmem_ack) begin
          dmem_req_d   = 1'b0;
          dmem_we_d    = 1'b0;
          dmem_wstrb_d = 4'b0000;
          mem_valid_d  = 1'b1;
          if (!dmem_we_q) begin
            mem_rw_data_d = load_data;
          end
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_wstrb_q  <= 4'b0000;
      dmem_wdata_q  <= '0;
      mem_valid_q   <= 1'b0;
      mem_pc_q      <= '0;
      mem_inst_q    <= '0;
      mem_rw_en_q   <= 1'b0;
      mem_rw_addr_q <= '0;
      mem_rw_data_q <= '0;
      mem_ale_q     <= 1'b0;
      op_q          <= '0;
      addr_lo_q     <= 2'b00;
    end else begin
      state_q       <= state_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_wstrb_q  <= dmem_wstrb_d;
      dmem_wdata_q  <= dmem_wdata_d;
      mem_valid_q   <= mem_valid_d;
      mem_pc_q      <= mem_pc_d;
      mem_inst_q    <= mem_inst_d;
      mem_rw_en_q   <= mem_rw_en_d;
      mem_rw_addr_q <= mem_rw_addr_d;
      mem_rw_data_q <= mem_rw_data_d;
      mem_ale_q     <= mem_ale_d;
      op_q          <= op_d;
      addr_lo_q     <= addr_lo_d;
    end
  end

  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wstrb   = dmem_wstrb_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign mem_valid    = mem_valid_q;
  assign mem_pc       = mem_pc_q;
  assign mem_inst     = mem_inst_q;
  assign mem_rw_en    = mem_rw_en_q;
  assign mem_rw_addr  = mem_rw_addr_q;
  assign mem_rw_data  = mem_rw_data_q;
  assign mem_excp_ale = mem_ale_q && mem_valid_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
//
// Directed bench for mem_stage_lsu: a table of single-instruction vectors
// with hand-computed results, followed by hand-written sequences for
// back-to-back issue, WB backpressure and reset in the middle of an access.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_inst;
  logic [31:0] ex_result;
  logic [3:0]  ex_lsu_op;
  logic [31:0] ex_lsu_data;
  logic        ex_rw_en;
  logic [4:0]  ex_rw_addr;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_pc;
  logic [31:0] mem_inst;
  logic        mem_rw_en;
  logic [4:0]  mem_rw_addr;
  logic [31:0] mem_rw_data;
  logic        mem_excp_ale;

  int checks;
  int errors;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [3:0]  ackDelay;
    logic        rwEn;
    logic        expReq;
    logic        expWe;
    logic [3:0]  expStrb;
    logic [31:0] expWdata;
    logic [31:0] expRwData;
    logic        expRwEn;
    logic        expAle;
  } vec_t;

  vec_t vecs[$];

  mem_stage_lsu dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_pc        (ex_pc),
    .ex_inst      (ex_inst),
    .ex_result    (ex_result),
    .ex_lsu_op    (ex_lsu_op),
    .ex_lsu_data  (ex_lsu_data),
    .ex_rw_en     (ex_rw_en),
    .ex_rw_addr   (ex_rw_addr),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wstrb   (dmem_wstrb),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_pc       (mem_pc),
    .mem_inst     (mem_inst),
    .mem_rw_en    (mem_rw_en),
    .mem_rw_addr  (mem_rw_addr),
    .mem_rw_data  (mem_rw_data),
    .mem_excp_ale (mem_excp_ale)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a stuck handshake still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] result,
                               input logic [31:0] data, input logic rwEn,
                               input logic [4:0] rwAddr, input logic [31:0] pc);
    ex_valid    = 1'b1;
    ex_lsu_op   = op;
    ex_result   = result;
    ex_lsu_data = data;
    ex_rw_en    = rwEn;
    ex_rw_addr  = rwAddr;
    ex_pc       = pc;
    ex_inst     = pc ^ 32'h0000_0013;
  endtask

  // Issue one table vector, serve the bus as described, check the payload.
  task automatic runVector(input int idx, input vec_t v);
    int reqCycles;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    mem_ready  = 1'b1;
    dmem_rdata = v.rdata;
    applyStimulus(v.op, v.addr, v.data, v.rwEn, 5'(idx + 1), 32'h1000 + 32'(idx * 4));
    checkOutput({tag, "_ex_ready"}, 32'(ex_ready), 32'd1);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    if (v.expReq) begin
      checkOutput({tag, "_valid_during_bus"}, 32'(mem_valid), 32'd0);
      checkOutput({tag, "_addr"}, dmem_addr, {v.addr[31:2], 2'b00});
      checkOutput({tag, "_we"}, 32'(dmem_we), 32'(v.expWe));
      checkOutput({tag, "_wstrb"}, 32'(dmem_wstrb), 32'(v.expStrb));
      if (v.expWe) checkOutput({tag, "_wdata"}, dmem_wdata, v.expWdata);
      reqCycles = 0;
      for (int c = 0; c <= int'(v.ackDelay); c++) begin
        @(negedge clk);
        if (dmem_req) reqCycles++;
        dmem_ack = (c == int'(v.ackDelay));
        @(posedge clk);
        #1;
      end
      dmem_ack = 1'b0;
      checkOutput({tag, "_req_cycles"}, 32'(reqCycles), 32'(v.ackDelay) + 32'd1);
    end
    checkOutput({tag, "_req_after"}, 32'(dmem_req), 32'd0);
    checkOutput({tag, "_valid"}, 32'(mem_valid), 32'd1);
    checkOutput({tag, "_rw_data"}, mem_rw_data, v.expRwData);
    checkOutput({tag, "_rw_en"}, 32'(mem_rw_en), 32'(v.expRwEn));
    checkOutput({tag, "_ale"}, 32'(mem_excp_ale), 32'(v.expAle));
    checkOutput({tag, "_rw_addr"}, 32'(mem_rw_addr), 32'(idx + 1));
    checkOutput({tag, "_pc"}, mem_pc, 32'h1000 + 32'(idx * 4));
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid_drop"}, 32'(mem_valid), 32'd0);
  endtask

  initial begin
    vec_t noneVec;
    logic [31:0] held;
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    ex_valid    = 1'b0;
    ex_pc       = '0;
    ex_inst     = '0;
    ex_result   = '0;
    ex_lsu_op   = '0;
    ex_lsu_data = '0;
    ex_rw_en    = 1'b0;
    ex_rw_addr  = '0;
    dmem_ack    = 1'b0;
    dmem_rdata  = '0;
    mem_ready   = 1'b1;

    //                 op     addr          data          rdata        dly rwEn req we  strb     wdata         rwData        rwEn ale
    vecs.push_back('{4'd0,  32'h0000_1234, 32'h0,        32'h0,        4'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_1234, 1'b1, 1'b0});
    vecs.push_back('{4'd12, 32'hDEAD_BEEF, 32'h0,        32'h0,        4'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b1, 1'b0});
    vecs.push_back('{4'd1,  32'h0000_0103, 32'h0,        32'h80FF_FF00, 4'd2, 1'b1, 1'b1, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b1, 1'b0});
    vecs.push_back('{4'd4,  32'h0000_0103, 32'h0,        32'h80FF_FF00, 4'd2, 1'b1, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0000_0080, 1'b1, 1'b0});
    vecs.push_back('{4'd1,  32'h0000_0101, 32'h0,        32'h80FF_FF00, 4'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FFFF, 1'b1, 1'b0});
    vecs.push_back('{4'd2,  32'h0000_0102, 32'h0,        32'h8001_1234, 4'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b1, 1'b0});
    vecs.push_back('{4'd5,  32'h0000_0100, 32'h0,        32'h8001_9234, 4'd1, 1'b1, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0000_9234, 1'b1, 1'b0});
    vecs.push_back('{4'd3,  32'h0000_0304, 32'h0,        32'hCAFE_BABE, 4'd1, 1'b1, 1'b1, 1'b0, 4'b0000, 32'h0,        32'hCAFE_BABE, 1'b1, 1'b0});
    vecs.push_back('{4'd6,  32'h0000_0401, 32'h1234_5678, 32'h0,        4'd0, 1'b0, 1'b1, 1'b1, 4'b0010, 32'h7878_7878, 32'h0000_0401, 1'b0, 1'b0});
    vecs.push_back('{4'd7,  32'h0000_0202, 32'h0000_ABCD, 32'h0,        4'd1, 1'b0, 1'b1, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0000_0202, 1'b0, 1'b0});
    vecs.push_back('{4'd8,  32'h0000_0500, 32'h1122_3344, 32'h0,        4'd0, 1'b0, 1'b1, 1'b1, 4'b1111, 32'h1122_3344, 32'h0000_0500, 1'b0, 1'b0});
    vecs.push_back('{4'd3,  32'h0000_0302, 32'h0,        32'h0,        4'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_0302, 1'b0, 1'b1});
    vecs.push_back('{4'd2,  32'h0000_0101, 32'h0,        32'h0,        4'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_0101, 1'b0, 1'b1});
    vecs.push_back('{4'd7,  32'h0000_0203, 32'h0,        32'h0,        4'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_0203, 1'b0, 1'b1});
    vecs.push_back('{4'd8,  32'h0000_0501, 32'h0,        32'h0,        4'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_0501, 1'b0, 1'b1});

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_dmem_we", 32'(dmem_we), 32'd0);
    checkOutput("rst_dmem_wstrb", 32'(dmem_wstrb), 32'd0);
    checkOutput("rst_mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("rst_mem_rw_en", 32'(mem_rw_en), 32'd0);
    checkOutput("rst_mem_ale", 32'(mem_excp_ale), 32'd0);
    checkOutput("rst_ex_ready", 32'(ex_ready), 32'd1);

    foreach (vecs[i]) runVector(i, vecs[i]);

    // Back-to-back NONE ops: one result per cycle, never a bubble.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(4'd0, 32'h0000_00A0 + 32'(i), 32'h0, 1'b1, 5'd3, 32'h2000);
      checkOutput($sformatf("b2b%0d_ex_ready", i), 32'(ex_ready), 32'd1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("b2b%0d_valid", i), 32'(mem_valid), 32'd1);
      checkOutput($sformatf("b2b%0d_data", i), mem_rw_data, 32'h0000_00A0 + 32'(i));
      checkOutput($sformatf("b2b%0d_req", i), 32'(dmem_req), 32'd0);
    end
    @(negedge clk);
    ex_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("b2b_drain", 32'(mem_valid), 32'd0);

    // WB backpressure after a load: payload held, EX blocked, one transfer.
    @(negedge clk);
    mem_ready  = 1'b0;
    dmem_rdata = 32'h1357_2468;
    applyStimulus(4'd3, 32'h0000_0010, 32'h0, 1'b1, 5'd9, 32'h3000);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    checkOutput("bp_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    dmem_ack = 1'b1;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    checkOutput("bp_valid", 32'(mem_valid), 32'd1);
    checkOutput("bp_data", mem_rw_data, 32'h1357_2468);
    held = mem_rw_data;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_hold%0d_ex_ready", i), 32'(ex_ready), 32'd0);
      checkOutput($sformatf("bp_hold%0d_valid", i), 32'(mem_valid), 32'd1);
      checkOutput($sformatf("bp_hold%0d_data", i), mem_rw_data, held);
      @(posedge clk);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", 32'(mem_valid), 32'd0);
    checkOutput("bp_release_ex_ready", 32'(ex_ready), 32'd1);

    // Reset in the middle of a bus access; a late ack must be ignored.
    @(negedge clk);
    applyStimulus(4'd3, 32'h0000_0020, 32'h0, 1'b1, 5'd4, 32'h4000);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    checkOutput("rstmid_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstmid_req_drop", 32'(dmem_req), 32'd0);
    checkOutput("rstmid_valid", 32'(mem_valid), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    dmem_ack = 1'b1;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    checkOutput("late_ack_valid", 32'(mem_valid), 32'd0);
    checkOutput("late_ack_req", 32'(dmem_req), 32'd0);
    noneVec = '{4'd0, 32'h0000_0055, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0, 1'b0,
                4'b0000, 32'h0, 32'h0000_0055, 1'b1, 1'b0};
    runVector(20, noneVec);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
